// File: rtl/banner_renderer.sv
// Text banner overlay: 5x7 glyph cells scaled by SCALE, with static, blink and
// slide-in presentation. The pixel-on output is registered one clock after x/y.
module banner_renderer #(
  parameter int N_CHARS      = 3,
  parameter int SCALE        = 4,
  parameter int GAP          = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int SLIDE_START  = 320,
  parameter int SLIDE_STEP   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 show,
  input  logic [1:0]           mode,
  input  logic                 frame_tick,
  input  logic [9:0]           start_x,
  input  logic [9:0]           start_y,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [6*N_CHARS-1:0] text,
  output logic                 display,
  output logic                 active,
  output logic                 anim_done
);

  localparam int PITCH = (5 + GAP) * SCALE;
  localparam int GW    = 14;
  localparam int CW    = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {S_IDLE, S_STATIC, S_BLINK, S_SLIDE, S_HOLD} state_t;

  state_t          r_state, w_state_next;
  logic [GW-1:0]   r_off, w_off_next;
  logic [CW-1:0]   r_blink_cnt, w_blink_next;
  logic            r_visible, w_visible_next;
  logic            r_anim_done, w_done_next;
  logic            r_show_prev;
  logic            r_display;

  // Row-major glyph: row 0 in bits [34:30], bit 4 of each row is the leftmost column.
  function automatic logic [34:0] font_glyph(input logic [5:0] code);
    case (code)
      6'd1:  return 35'b01110_10001_10001_11111_10001_10001_10001;
      6'd2:  return 35'b11110_10001_10001_11110_10001_10001_11110;
      6'd3:  return 35'b01110_10001_10000_10000_10000_10001_01110;
      6'd4:  return 35'b11110_10001_10001_10001_10001_10001_11110;
      6'd5:  return 35'b11111_10000_10000_11110_10000_10000_11111;
      6'd6:  return 35'b11111_10000_10000_11110_10000_10000_10000;
      6'd7:  return 35'b01110_10001_10000_10111_10001_10001_01111;
      6'd8:  return 35'b10001_10001_10001_11111_10001_10001_10001;
      6'd9:  return 35'b01110_00100_00100_00100_00100_00100_01110;
      6'd10: return 35'b00111_00010_00010_00010_00010_10010_01100;
      6'd11: return 35'b10001_10010_10100_11000_10100_10010_10001;
      6'd12: return 35'b10000_10000_10000_10000_10000_10000_11111;
      6'd13: return 35'b10001_11011_10101_10101_10001_10001_10001;
      6'd14: return 35'b10001_11001_10101_10011_10001_10001_10001;
      6'd15: return 35'b01110_10001_10001_10001_10001_10001_01110;
      6'd16: return 35'b11110_10001_10001_11110_10000_10000_10000;
      6'd17: return 35'b01110_10001_10001_10001_10101_10010_01101;
      6'd18: return 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd19: return 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd20: return 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd21: return 35'b10001_10001_10001_10001_10001_10001_01110;
      6'd22: return 35'b10001_10001_10001_10001_10001_01010_00100;
      6'd23: return 35'b10001_10001_10001_10101_10101_10101_01010;
      6'd24: return 35'b10001_10001_01010_00100_01010_10001_10001;
      6'd25: return 35'b10001_10001_01010_00100_00100_00100_00100;
      6'd26: return 35'b11111_00001_00010_00100_01000_10000_11111;
      6'd27: return 35'b01110_10001_10011_10101_11001_10001_01110;
      6'd28: return 35'b00100_01100_00100_00100_00100_00100_01110;
      6'd29: return 35'b01110_10001_00001_00010_00100_01000_11111;
      6'd30: return 35'b11111_00010_00100_00010_00001_10001_01110;
      6'd31: return 35'b00010_00110_01010_10010_11111_00010_00010;
      6'd32: return 35'b11111_10000_11110_00001_00001_10001_01110;
      6'd33: return 35'b00110_01000_10000_11110_10001_10001_01110;
      6'd34: return 35'b11111_00001_00010_00100_01000_01000_01000;
      6'd35: return 35'b01110_10001_10001_01110_10001_10001_01110;
      6'd36: return 35'b01110_10001_10001_01111_00001_00010_01100;
      default: return 35'd0;
    endcase
  endfunction

  // Geometry is done wide enough that start_x + offsets never wraps back on-screen.
  logic [GW-1:0]      w_dy;
  logic [2:0]         w_row;
  logic               w_in_y;
  logic [N_CHARS-1:0] w_hit;
  logic               w_pix_on;

  assign w_in_y = (GW'(y) >= GW'(start_y)) && (GW'(y) < GW'(start_y) + GW'(7 * SCALE));
  assign w_dy   = GW'(y) - GW'(start_y);
  assign w_row  = 3'(w_dy / GW'(SCALE));

  genvar gi;
  generate
    for (gi = 0; gi < N_CHARS; gi++) begin : g_cell
      logic [5:0]    w_code;
      logic [GW-1:0] w_left, w_dx;
      logic          w_in_x;
      logic [2:0]    w_col;
      logic [34:0]   w_rows;
      logic [4:0]    w_bits;

      assign w_code = text[6*gi +: 6];
      assign w_left = GW'(start_x) + GW'(gi * PITCH) + r_off;
      assign w_in_x = (GW'(x) >= w_left) && (GW'(x) < w_left + GW'(5 * SCALE));
      assign w_dx   = GW'(x) - w_left;
      assign w_col  = 3'(w_dx / GW'(SCALE));
      assign w_rows = font_glyph(w_code) << (5 * w_row);
      assign w_bits = w_rows[34:30] << w_col;
      assign w_hit[gi] = w_in_x && w_bits[4];
    end
  endgenerate

  assign w_pix_on = w_in_y && (|w_hit) && r_visible && (r_state != S_IDLE);

  always_comb begin
    w_state_next   = r_state;
    w_off_next     = r_off;
    w_blink_next   = r_blink_cnt;
    w_visible_next = r_visible;
    w_done_next    = 1'b0;
    if (!show) begin
      // Dropping show wins over everything, including a coincident frame_tick.
      w_state_next   = S_IDLE;
      w_off_next     = '0;
      w_visible_next = 1'b1;
      w_blink_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_show_prev) begin
            w_visible_next = 1'b1;
            w_blink_next   = '0;
            w_off_next     = '0;
            case (mode)
              2'd1: w_state_next = S_BLINK;
              2'd2: begin
                w_state_next = S_SLIDE;
                w_off_next   = GW'(SLIDE_START);
              end
              default: w_state_next = S_STATIC;
            endcase
          end
        end
        S_BLINK: begin
          if (frame_tick) begin
            if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
              w_visible_next = ~r_visible;
              w_blink_next   = '0;
            end else begin
              w_blink_next = r_blink_cnt + 1'b1;
            end
          end
        end
        S_SLIDE: begin
          if (frame_tick) begin
            if (r_off <= GW'(SLIDE_STEP)) begin
              w_off_next   = '0;
              w_state_next = S_HOLD;
              w_done_next  = 1'b1;
            end else begin
              w_off_next = r_off - GW'(SLIDE_STEP);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
      r_anim_done <= 1'b0;
      r_show_prev <= 1'b0;
      r_display   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_off       <= w_off_next;
      r_blink_cnt <= w_blink_next;
      r_visible   <= w_visible_next;
      r_anim_done <= w_done_next;
      r_show_prev <= show;
      r_display   <= w_pix_on;
    end
  end

  assign display   = r_display;
  assign active    = (r_state != S_IDLE);
  assign anim_done = r_anim_done;

endmodule

// File: tb/tb_banner_renderer.sv
// Randomized pixel probes against a frame-count based reference of the banner.
module tb_banner_renderer;
  localparam int N = 3, SC = 4, GP = 1, BF = 30, SS = 320, ST = 8;
  localparam int PITCH = (5 + GP) * SC;

  logic           clk = 1'b0;
  logic           reset, show, frame_tick;
  logic [1:0]     mode;
  logic [9:0]     start_x, start_y, x, y;
  logic [6*N-1:0] text;
  logic           display, active, anim_done;

  int n_checks = 0, n_pass = 0, pulses = 0;
  int m_act, m_vis, m_off;

  banner_renderer #(.N_CHARS(N), .SCALE(SC), .GAP(GP), .BLINK_FRAMES(BF),
                    .SLIDE_START(SS), .SLIDE_STEP(ST)) dut (
    .clk(clk), .reset(reset), .show(show), .mode(mode), .frame_tick(frame_tick),
    .start_x(start_x), .start_y(start_y), .x(x), .y(y), .text(text),
    .display(display), .active(active), .anim_done(anim_done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (anim_done) pulses++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference font for the codes the bench uses; anything else is blank.
  function automatic logic [4:0] glyph_row(input int code, input int row);
    logic [34:0] g;
    g = '0;
    if (code == 4)  g = 35'b11110_10001_10001_10001_10001_10001_11110;
    if (code == 5)  g = 35'b11111_10000_10000_11110_10000_10000_11111;
    if (code == 14) g = 35'b10001_11001_10101_10011_10001_10001_10001;
    return g[34-5*row -: 5];
  endfunction

  function automatic int model_px(input int px, input int py);
    int left, sx, sy;
    logic [4:0] r;
    sx = int'(start_x);
    sy = int'(start_y);
    if (m_act == 0 || m_vis == 0) return 0;
    for (int i = 0; i < N; i++) begin
      left = sx + i * PITCH + m_off;
      if (px >= left && px < left + 5 * SC && py >= sy && py < sy + 7 * SC) begin
        r = glyph_row(int'(text[6*i +: 6]), (py - sy) / SC);
        return int'(r[4 - (px - left) / SC]);
      end
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input string tag);
    x = 10'(px);
    y = 10'(py);
    step();
    check_val(tag, int'(display), model_px(px, py));
  endtask

  task automatic rand_pix(input int n, input int xlo, input int xhi, input string tag);
    for (int k = 0; k < n; k++)
      pix(int'($urandom_range(xhi, xlo)), int'($urandom_range(80, 45)), tag);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic go_idle();
    show = 1'b0;
    step();
    m_act = 0; m_vis = 1; m_off = 0;
  endtask

  initial begin
    reset = 1'b1; show = 1'b0; mode = 2'd0; frame_tick = 1'b0;
    start_x = 10'd100; start_y = 10'd50; x = '0; y = '0;
    text = {6'd4, 6'd14, 6'd5};
    m_act = 0; m_vis = 1; m_off = 0;
    step(); step();
    check_val("reset_display", int'(display), 0);
    check_val("reset_active", int'(active), 0);
    check_val("reset_done", int'(anim_done), 0);
    reset = 1'b0;
    step();

    // Static mode
    show = 1'b1; mode = 2'd0;
    step();
    m_act = 1;
    check_val("static_active", int'(active), 1);
    pix(100, 50, "static_e0");
    pix(120, 50, "static_gap");
    pix(124, 50, "static_n0");
    pix(99, 50, "static_left");
    check_val("static_e0_exp", model_px(100, 50), 1);
    rand_pix(40, 90, 180, "static_rand");
    mode = 2'd1;
    for (int t = 0; t < BF + 5; t++) tick();
    pix(100, 50, "static_mode_ignored");
    go_idle();
    check_val("idle_active", int'(active), 0);
    rand_pix(10, 90, 180, "idle_rand");

    // Blink mode
    show = 1'b1; mode = 2'd1;
    step();
    m_act = 1;
    for (int t = 1; t <= 2 * BF; t++) begin
      tick();
      m_vis = ((t / BF) % 2 == 0) ? 1 : 0;
      if (t % 10 == 0 || t == BF - 1 || t == BF) pix(100, 50, "blink_px");
    end
    check_val("blink_done_low", pulses, 0);
    pix(100, 50, "blink_back_on");
    reset = 1'b1;
    #1;
    check_val("async_rst_display", int'(display), 0);
    check_val("async_rst_active", int'(active), 0);
    show = 1'b0;
    step();
    reset = 1'b0;
    m_act = 0; m_vis = 1;
    step();
    show = 1'b1;
    step();
    m_act = 1;
    pix(100, 50, "blink_restart");

    // Slide mode
    go_idle();
    show = 1'b1; mode = 2'd2;
    step();
    m_act = 1; m_off = SS;
    pix(100, 50, "slide_start_home");
    pix(420, 50, "slide_start_far");
    for (int t = 1; t <= SS / ST; t++) begin
      tick();
      check_val("slide_done_pulse", int'(anim_done), (t == SS / ST) ? 1 : 0);
      m_off = (SS - ST * t > 0) ? SS - ST * t : 0;
      if (t % 8 == 0) rand_pix(3, 90, 460, "slide_rand");
    end
    step();
    check_val("slide_pulse_count", pulses, 1);
    pix(100, 50, "hold_home");
    rand_pix(10, 90, 180, "hold_rand");

    // Abort during slide: fall coincides with a tick
    go_idle();
    show = 1'b1; mode = 2'd2;
    step();
    m_act = 1; m_off = SS;
    for (int t = 1; t < 10; t++) tick();
    frame_tick = 1'b1; show = 1'b0;
    step();
    frame_tick = 1'b0;
    m_act = 0; m_off = 0;
    check_val("abort_active", int'(active), 0);
    check_val("abort_done", int'(anim_done), 0);
    pix(100, 50, "abort_px");
    check_val("abort_pulse_count", pulses, 1);

    // Show held through reset release counts as a rising edge
    show = 1'b1; mode = 2'd0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    m_act = 1;
    check_val("rst_release_edge", int'(active), 1);

    // Right-edge placement must not wrap to the left
    start_x = 10'd1020;
    for (int k = 0; k < 20; k++) pix(k + 20, 50 + k, "edge_nowrap");
    rand_pix(20, 0, 1023, "edge_rand");

    // Out-of-range code renders blank
    start_x = 10'd100;
    text = {6'd4, 6'd40, 6'd5};
    pix(124, 50, "code40_blank");
    rand_pix(20, 118, 146, "code40_rand");
    pix(148, 50, "code40_d0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
